// File: rtl/pio_pkg.sv
// Shared definitions for the pio loader: pio action codes, loader FSM
// states and the per-machine configuration step order.
package pio_pkg;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] INSTR = 4'd1;
    localparam logic [3:0] PEND  = 4'd2;
    localparam logic [3:0] PULL  = 4'd3;
    localparam logic [3:0] PUSH  = 4'd4;
    localparam logic [3:0] GRPS  = 4'd5;
    localparam logic [3:0] EN    = 4'd6;
    localparam logic [3:0] DIV   = 4'd7;
    localparam logic [3:0] SIDES = 4'd8;
    localparam logic [3:0] IMM   = 4'd9;
    localparam logic [3:0] SHIFT = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DIS   = 3'd1,
        S_FETCH = 3'd2,
        S_INSTR = 3'd3,
        S_SMCFG = 3'd4,
        S_EN    = 3'd5,
        S_RUN   = 3'd6
    } state_t;

    // Order in which one machine's registers are written during SMCFG.
    function automatic logic [3:0] smcfg_action(input logic [1:0] step);
        logic [3:0] act;
        case (step)
            2'd0:    act = PEND;
            2'd1:    act = DIV;
            2'd2:    act = GRPS;
            2'd3:    act = SHIFT;
            default: act = NONE;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/pio_loader_if.sv
// Host request/response port of the pio loader.
interface pio_loader_if #(parameter int MW = 2);

    logic          host_valid;
    logic          host_ready;
    logic [3:0]    host_action;
    logic [MW-1:0] host_mindex;
    logic [31:0]   host_din;
    logic [31:0]   rdata;
    logic          rdata_valid;
    logic          host_err;

    modport master (
        output host_valid, host_action, host_mindex, host_din,
        input  host_ready, rdata, rdata_valid, host_err
    );

    modport slave (
        input  host_valid, host_action, host_mindex, host_din,
        output host_ready, rdata, rdata_valid, host_err
    );

endinterface

// File: rtl/pio_host_gate.sv
// Combinational legality and FIFO-flag check for host requests.
// Illegal codes are still "ready" so they are consumed and reported.
module pio_host_gate
    import pio_pkg::*;
#(
    parameter int NSM = 4,
    parameter int MW  = 2
) (
    input  logic [3:0]     action,
    input  logic [MW-1:0]  mindex,
    input  logic [NSM-1:0] tx_full,
    input  logic [NSM-1:0] rx_empty,
    output logic           ready,
    output logic           illegal
);

    // Decide acceptance from the action code and the addressed machine's flags.
    always_comb begin
        ready   = 1'b0;
        illegal = 1'b0;
        case (action)
            NONE, IMM: ready = 1'b1;
            PUSH:      ready = ~tx_full[mindex];
            PULL:      ready = ~rx_empty[mindex];
            default: begin
                ready   = 1'b1;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pio_loader.sv
// Configuration sequencer and runtime host port for the pio block.
// Optional build macro PIO_LOADER_PAD_EN: pad the remainder of instruction
// memory (plen..PLEN_MAX-1) with 16'h0000 before machine configuration.
module pio_loader
    import pio_pkg::*;
#(
    parameter  int PLEN_MAX = 32,
    parameter  int NSM      = 4,
    localparam int MW       = $clog2(NSM)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [5:0]     plen,
    input  logic [NSM-1:0] sm_mask,
    input  logic [31:0]    exec_ctrl,
    input  logic [23:0]    div,
    input  logic [31:0]    pin_grps,
    input  logic [31:0]    shift_ctrl,
    output logic [4:0]     prog_addr,
    input  logic [15:0]    prog_data,
    output logic [3:0]     action,
    output logic [4:0]     index,
    output logic [MW-1:0]  mindex,
    output logic [31:0]    din,
    input  logic [31:0]    dout,
    input  logic [NSM-1:0] tx_full,
    input  logic [NSM-1:0] rx_empty,
    output logic           busy,
    output logic           done,
    pio_loader_if.slave    host
);

    state_t         state_r, state_n, post_state_s;
    logic [5:0]     cnt_r, cnt_n, total_s;
    logic [MW-1:0]  sm_r, sm_n, first_s, next_s;
    logic           has_next_s;
    logic [1:0]     step_r, step_n;
    logic           load_s, gate_ready_s, illegal_s, host_ready_s;

    logic [5:0]     cfg_plen_r;
    logic [NSM-1:0] cfg_mask_r;
    logic [31:0]    cfg_exec_r, cfg_grps_r, cfg_shift_r;
    logic [23:0]    cfg_div_r;

    logic [3:0]     action_r, action_n;
    logic [4:0]     index_r, index_n, prog_addr_r, prog_addr_n;
    logic [MW-1:0]  mindex_r, mindex_n;
    logic [31:0]    din_r, din_n, rdata_r;
    logic           din_rom_r, din_rom_n, busy_r, busy_n, done_r, done_n;
    logic           host_err_r, host_err_n, rdata_valid_r;

    assign load_s = start && ((state_r == S_IDLE) || (state_r == S_RUN));

`ifdef PIO_LOADER_PAD_EN
    assign total_s = 6'(PLEN_MAX);
`else
    assign total_s = cfg_plen_r;
`endif

    pio_host_gate #(.NSM(NSM), .MW(MW)) u_gate (
        .action   (host.host_action),
        .mindex   (host.host_mindex),
        .tx_full  (tx_full),
        .rx_empty (rx_empty),
        .ready    (gate_ready_s),
        .illegal  (illegal_s)
    );

    // A start request always wins over a host request in the same cycle.
    assign host_ready_s = (state_r == S_RUN) && !start && gate_ready_s;

    // Lowest enabled machine, and the next enabled machine above the current one.
    always_comb begin
        first_s    = '0;
        next_s     = '0;
        has_next_s = 1'b0;
        for (int i = NSM - 1; i >= 0; i--) begin
            if (cfg_mask_r[i]) begin
                first_s = MW'(i);
            end else begin
                first_s = first_s;
            end
            if (cfg_mask_r[i] && (i > int'(sm_r))) begin
                has_next_s = 1'b1;
                next_s     = MW'(i);
            end else begin
                has_next_s = has_next_s;
            end
        end
    end

    // Where the sequence goes once instruction memory is written.
    always_comb begin
        if (cfg_mask_r != '0) begin
            post_state_s = S_SMCFG;
        end else begin
            post_state_s = S_EN;
        end
    end

    // Latch the configuration words when a (re)load begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_plen_r  <= 6'd0;
            cfg_mask_r  <= '0;
            cfg_exec_r  <= 32'd0;
            cfg_div_r   <= 24'd0;
            cfg_grps_r  <= 32'd0;
            cfg_shift_r <= 32'd0;
        end else if (load_s) begin
            cfg_plen_r  <= (plen > 6'(PLEN_MAX)) ? 6'(PLEN_MAX) : plen;
            cfg_mask_r  <= sm_mask;
            cfg_exec_r  <= exec_ctrl;
            cfg_div_r   <= div;
            cfg_grps_r  <= pin_grps;
            cfg_shift_r <= shift_ctrl;
        end
    end

    // FSM state and sequencing counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            cnt_r   <= 6'd0;
            sm_r    <= '0;
            step_r  <= 2'd0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            sm_r    <= sm_n;
            step_r  <= step_n;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        sm_n    = sm_r;
        step_n  = step_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_n = S_DIS;
                else       state_n = S_IDLE;
            end
            S_DIS: begin
                cnt_n = 6'd0;
                if (total_s != 6'd0) begin
                    state_n = S_FETCH;
                end else begin
                    state_n = post_state_s;
                    sm_n    = first_s;
                    step_n  = 2'd0;
                end
            end
            S_FETCH: begin
                state_n = S_INSTR;
                cnt_n   = 6'd0;
            end
            S_INSTR: begin
                if (cnt_r == total_s - 6'd1) begin
                    state_n = post_state_s;
                    sm_n    = first_s;
                    step_n  = 2'd0;
                end else begin
                    cnt_n = cnt_r + 6'd1;
                end
            end
            S_SMCFG: begin
                if (step_r == 2'd3) begin
                    step_n = 2'd0;
                    if (has_next_s) sm_n    = next_s;
                    else            state_n = S_EN;
                end else begin
                    step_n = step_r + 2'd1;
                end
            end
            S_EN: state_n = S_RUN;
            S_RUN: begin
                if (start) state_n = S_DIS;
                else       state_n = S_RUN;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered.
    always_comb begin
        action_n    = NONE;
        index_n     = index_r;
        mindex_n    = mindex_r;
        din_n       = din_r;
        din_rom_n   = 1'b0;
        prog_addr_n = prog_addr_r;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        host_err_n  = 1'b0;
        case (state_n)
            S_DIS: begin
                action_n    = EN;
                din_n       = 32'd0;
                prog_addr_n = 5'd0;
                busy_n      = 1'b1;
            end
            S_FETCH: begin
                prog_addr_n = 5'd0;
                busy_n      = 1'b1;
            end
            S_INSTR: begin
                action_n    = INSTR;
                index_n     = cnt_n[4:0];
                prog_addr_n = cnt_n[4:0] + 5'd1;
                din_n       = 32'd0;
                din_rom_n   = (cnt_n < cfg_plen_r);
                busy_n      = 1'b1;
            end
            S_SMCFG: begin
                action_n = smcfg_action(step_n);
                mindex_n = sm_n;
                busy_n   = 1'b1;
                case (step_n)
                    2'd0:    din_n = cfg_exec_r;
                    2'd1:    din_n = {8'd0, cfg_div_r};
                    2'd2:    din_n = cfg_grps_r;
                    2'd3:    din_n = cfg_shift_r;
                    default: din_n = 32'd0;
                endcase
            end
            S_EN: begin
                action_n = EN;
                din_n    = 32'(cfg_mask_r);
                busy_n   = 1'b1;
            end
            S_RUN: begin
                done_n = 1'b1;
                if (host.host_valid && host_ready_s) begin
                    if (illegal_s) begin
                        host_err_n = 1'b1;
                    end else begin
                        action_n = host.host_action;
                        mindex_n = host.host_mindex;
                        din_n    = host.host_din;
                    end
                end else begin
                    host_err_n = 1'b0;
                end
            end
            default: action_n = NONE;
        endcase
    end

    // Output registers toward pio, ROM and host.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            action_r    <= NONE;
            index_r     <= 5'd0;
            mindex_r    <= '0;
            din_r       <= 32'd0;
            din_rom_r   <= 1'b0;
            prog_addr_r <= 5'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            host_err_r  <= 1'b0;
        end else begin
            action_r    <= action_n;
            index_r     <= index_n;
            mindex_r    <= mindex_n;
            din_r       <= din_n;
            din_rom_r   <= din_rom_n;
            prog_addr_r <= prog_addr_n;
            busy_r      <= busy_n;
            done_r      <= done_n;
            host_err_r  <= host_err_n;
        end
    end

    // Capture pio read data at the end of a PULL cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r       <= 32'd0;
            rdata_valid_r <= 1'b0;
        end else if (action_r == PULL) begin
            rdata_r       <= dout;
            rdata_valid_r <= 1'b1;
        end else begin
            rdata_valid_r <= 1'b0;
        end
    end

    assign action    = action_r;
    assign index     = index_r;
    assign mindex    = mindex_r;
    // Program words come straight from the sync ROM's output register so
    // that INSTR i lines up with prog_addr running one ahead.
    assign din       = din_rom_r ? {16'd0, prog_data} : din_r;
    assign prog_addr = prog_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;

    assign host.host_ready  = host_ready_s;
    assign host.rdata       = rdata_r;
    assign host.rdata_valid = rdata_valid_r;
    assign host.host_err    = host_err_r;

endmodule

// File: tb/tb_pio_loader.sv
// Directed testbench for pio_loader.
module tb_pio_loader;

    logic        clk = 1'b0;
    logic        reset_n, start;
    logic [5:0]  plen;
    logic [3:0]  sm_mask, tx_full, rx_empty;
    logic [31:0] exec_ctrl, pin_grps, shift_ctrl, din, dout;
    logic [23:0] div;
    logic [4:0]  prog_addr, index;
    logic [15:0] prog_data;
    logic [3:0]  action;
    logic [1:0]  mindex;
    logic        busy, done;

    logic [15:0] rom [32];
    logic [31:0] e_exec, e_div, e_grps, e_shift;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pio_loader_if #(.MW(2)) hif ();

    pio_loader #(.PLEN_MAX(32), .NSM(4)) dut (
        .clk (clk), .reset_n (reset_n), .start (start), .plen (plen),
        .sm_mask (sm_mask), .exec_ctrl (exec_ctrl), .div (div),
        .pin_grps (pin_grps), .shift_ctrl (shift_ctrl),
        .prog_addr (prog_addr), .prog_data (prog_data),
        .action (action), .index (index), .mindex (mindex), .din (din),
        .dout (dout), .tx_full (tx_full), .rx_empty (rx_empty),
        .busy (busy), .done (done), .host (hif)
    );

    always @(posedge clk) prog_data <= rom[prog_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic [3:0] act, input logic [4:0] idx,
                                input logic [1:0] mi, input logic [31:0] d);
        tick();
        check({tag, " action"}, 32'(action), 32'(act));
        if (act == 4'd1) check({tag, " index"}, 32'(index), 32'(idx));
        if (act inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd10})
            check({tag, " mindex"}, 32'(mindex), 32'(mi));
        if (act != 4'd0) check({tag, " din"}, din, d);
    endtask

    task automatic instr_phase(input int pl);
        int total;
`ifdef PIO_LOADER_PAD_EN
        total = 32;
`else
        total = pl;
`endif
        if (total > 0) begin
            expect_cycle("fetch", 4'd0, 5'd0, 2'd0, 32'd0);
            check("fetch prog_addr", 32'(prog_addr), 32'd0);
            for (int i = 0; i < total; i++) begin
                expect_cycle("instr", 4'd1, 5'(i), 2'd0, (i < pl) ? {16'd0, rom[i]} : 32'd0);
                check("instr prog_addr", 32'(prog_addr), 32'((i + 1) % 32));
            end
        end
    endtask

    task automatic smcfg(input logic [1:0] mi);
        expect_cycle("pend",  4'd2,  5'd0, mi, e_exec);
        expect_cycle("div",   4'd7,  5'd0, mi, e_div);
        expect_cycle("grps",  4'd5,  5'd0, mi, e_grps);
        expect_cycle("shift", 4'd10, 5'd0, mi, e_shift);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'hE000 + 16'(i);
        reset_n = 1'b0; start = 1'b0; plen = 6'd0; sm_mask = 4'd0;
        exec_ctrl = 32'd0; div = 24'd0; pin_grps = 32'd0; shift_ctrl = 32'd0;
        dout = 32'd0; tx_full = 4'd0; rx_empty = 4'hF;
        hif.host_valid = 1'b0; hif.host_action = 4'd0; hif.host_mindex = 2'd0; hif.host_din = 32'd0;

        // Reset state
        #12;
        check("rst action", 32'(action), 32'd0);
        check("rst index", 32'(index), 32'd0);
        check("rst mindex", 32'(mindex), 32'd0);
        check("rst din", din, 32'd0);
        check("rst prog_addr", 32'(prog_addr), 32'd0);
        check("rst rdata", hif.rdata, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst rdata_valid", 32'(hif.rdata_valid), 32'd0);
        check("rst host_err", 32'(hif.host_err), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        tick();
        hif.host_valid = 1'b1;
        #1;
        check("idle host_ready", 32'(hif.host_ready), 32'd0);
        hif.host_valid = 1'b0;
        tick();

        // Test 1: plen=4, one machine; inputs changed after start must be ignored
        plen = 6'd4; sm_mask = 4'b0001;
        exec_ctrl = 32'h0000_0041; div = 24'hABCDEF; pin_grps = 32'h1234_5678; shift_ctrl = 32'h8001_0000;
        e_exec = 32'h0000_0041; e_div = 32'h00AB_CDEF; e_grps = 32'h1234_5678; e_shift = 32'h8001_0000;
        start = 1'b1;
        expect_cycle("t1 dis", 4'd6, 5'd0, 2'd0, 32'd0);
        check("t1 busy", 32'(busy), 32'd1);
        start = 1'b0;
        plen = 6'd2; sm_mask = 4'hF; exec_ctrl = 32'd0; div = 24'd0; pin_grps = 32'd0; shift_ctrl = 32'd0;
        instr_phase(4);
        smcfg(2'd0);
        expect_cycle("t1 en", 4'd6, 5'd0, 2'd0, 32'd1);
        check("t1 en busy", 32'(busy), 32'd1);
        check("t1 en done", 32'(done), 32'd0);
        tick();
        check("t1 run action", 32'(action), 32'd0);
        check("t1 run done", 32'(done), 32'd1);
        check("t1 run busy", 32'(busy), 32'd0);

        // Test 2: empty program, no machines, restarted from RUN
        plen = 6'd0; sm_mask = 4'd0;
        start = 1'b1;
        expect_cycle("t2 dis", 4'd6, 5'd0, 2'd0, 32'd0);
        check("t2 dis prog_addr", 32'(prog_addr), 32'd0);
        start = 1'b0;
        instr_phase(0);
        expect_cycle("t2 en", 4'd6, 5'd0, 2'd0, 32'd0);
        check("t2 en prog_addr", 32'(prog_addr), 32'd0);
        tick();
        check("t2 done", 32'(done), 32'd1);

        // Test 3: machines 1 and 3
        sm_mask = 4'b1010;
        exec_ctrl = 32'hDEAD_0003; div = 24'h000102; pin_grps = 32'h0F0F_0F0F; shift_ctrl = 32'h4000_0020;
        e_exec = 32'hDEAD_0003; e_div = 32'h0000_0102; e_grps = 32'h0F0F_0F0F; e_shift = 32'h4000_0020;
        start = 1'b1;
        expect_cycle("t3 dis", 4'd6, 5'd0, 2'd0, 32'd0);
        start = 1'b0;
        instr_phase(0);
        smcfg(2'd1);
        smcfg(2'd3);
        expect_cycle("t3 en", 4'd6, 5'd0, 2'd0, 32'h0000_000A);
        tick();
        check("t3 done", 32'(done), 32'd1);

        // Test 4: PUSH blocked by tx_full, then PULL
        tx_full = 4'b0001;
        hif.host_valid = 1'b1; hif.host_action = 4'd4; hif.host_mindex = 2'd0; hif.host_din = 32'hCAFE_0001;
        #1;
        check("t4 push blocked", 32'(hif.host_ready), 32'd0);
        tick();
        check("t4 push held action", 32'(action), 32'd0);
        check("t4 push still blocked", 32'(hif.host_ready), 32'd0);
        tx_full = 4'b0000;
        #1;
        check("t4 push ready", 32'(hif.host_ready), 32'd1);
        expect_cycle("t4 push", 4'd4, 5'd0, 2'd0, 32'hCAFE_0001);
        hif.host_valid = 1'b0;
        tick();
        check("t4 push single", 32'(action), 32'd0);
        rx_empty = 4'b0100; dout = 32'h0000_0055;
        hif.host_valid = 1'b1; hif.host_action = 4'd3; hif.host_mindex = 2'd2;
        #1;
        check("t4 pull blocked", 32'(hif.host_ready), 32'd0);
        hif.host_mindex = 2'd1;
        #1;
        check("t4 pull ready", 32'(hif.host_ready), 32'd1);
        expect_cycle("t4 pull", 4'd3, 5'd0, 2'd1, 32'hCAFE_0001);
        hif.host_valid = 1'b0;
        check("t4 rdata_valid early", 32'(hif.rdata_valid), 32'd0);
        tick();
        check("t4 rdata", hif.rdata, 32'h0000_0055);
        check("t4 rdata_valid", 32'(hif.rdata_valid), 32'd1);
        tick();
        check("t4 rdata_valid pulse", 32'(hif.rdata_valid), 32'd0);

        // Test 5: illegal host action, then start beating a host request
        hif.host_valid = 1'b1; hif.host_action = 4'd6; hif.host_mindex = 2'd0;
        #1;
        check("t5 illegal ready", 32'(hif.host_ready), 32'd1);
        tick();
        check("t5 host_err", 32'(hif.host_err), 32'd1);
        check("t5 illegal action", 32'(action), 32'd0);
        hif.host_valid = 1'b0;
        tick();
        check("t5 host_err pulse", 32'(hif.host_err), 32'd0);
        plen = 6'd4; sm_mask = 4'b0001;
        hif.host_valid = 1'b1; hif.host_action = 4'd9;
        start = 1'b1;
        #1;
        check("t5 start beats host", 32'(hif.host_ready), 32'd0);
        expect_cycle("t5 dis", 4'd6, 5'd0, 2'd0, 32'd0);
        check("t5 busy", 32'(busy), 32'd1);
        start = 1'b0;
        hif.host_valid = 1'b0;

        // Test 6: async reset in the middle of INSTR
        expect_cycle("t6 fetch", 4'd0, 5'd0, 2'd0, 32'd0);
        expect_cycle("t6 instr0", 4'd1, 5'd0, 2'd0, {16'd0, rom[0]});
        expect_cycle("t6 instr1", 4'd1, 5'd1, 2'd0, {16'd0, rom[1]});
        #2 reset_n = 1'b0;
        #1;
        check("t6 rst action", 32'(action), 32'd0);
        check("t6 rst busy", 32'(busy), 32'd0);
        check("t6 rst index", 32'(index), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("t6 idle action", 32'(action), 32'd0);
        check("t6 idle busy", 32'(busy), 32'd0);
        check("t6 idle done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
